// File: rtl/reg_file_init.sv
// Integer register file with a post-reset clearing sequencer.
// Optional write-through read bypass: define RF_BYPASS_EN.
module reg_file_init #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] A1,
  input  logic [ADDR_WIDTH-1:0] A2,
  input  logic [ADDR_WIDTH-1:0] A3,
  input  logic [DATA_WIDTH-1:0] WD3,
  input  logic                  WE3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic                  rf_ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic                  rf_ready_q, rf_ready_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic ready;
  logic byp1;
  logic byp2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_ptr_q  <= {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      rf_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rf_ready_q <= rf_ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rf_ready_d = rf_ready_q;
    mem_we     = 1'b0;
    mem_waddr  = A3;
    mem_wdata  = WD3;
    unique case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
        clr_ptr_d = clr_ptr_q + 1'b1;
        // Last entry cleared: pointer wrap is never observed
        if (clr_ptr_q == '1) begin
          state_d    = READY;
          rf_ready_d = 1'b1;
        end
      end
      READY: begin
        mem_we = WE3 && (A3 != '0);
      end
    endcase
  end

  // Storage deliberately has no reset; the sequencer clears it
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ready = (state_q == READY);

`ifdef RF_BYPASS_EN
  assign byp1 = WE3 && (A3 != '0) && (A3 == A1);
  assign byp2 = WE3 && (A3 != '0) && (A3 == A2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (ready && (A1 != '0)) begin
      RD1 = byp1 ? WD3 : mem_q[A1];
    end
    if (ready && (A2 != '0)) begin
      RD2 = byp2 ? WD3 : mem_q[A2];
    end
  end

  assign rf_ready = rf_ready_q;

endmodule

// File: tb/tb_reg_file_init.sv
// Directed bench for reg_file_init: init sequencing, writes, x0,
// read-during-write and reset in CLEAR / READY.
module tb_reg_file_init;

  logic        clk;
  logic        rst_n;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD3;
  logic        WE3;
  logic [31:0] RD1, RD2;
  logic        rf_ready;

  int checks;
  int errors;

  reg_file_init #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A1      (A1),
    .A2      (A2),
    .A3      (A3),
    .WD3     (WD3),
    .WE3     (WE3),
    .RD1     (RD1),
    .RD2     (RD2),
    .rf_ready(rf_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] pre1;
    logic [31:0] pre2;
    logic [31:0] post1;
    logic [31:0] post2;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts edges until rf_ready is seen high; -1 on timeout
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (rf_ready === 1'b1) begin
        n = i;
        return;
      end
    end
  endtask

  int n;
  logic [31:0] exp_rdw;

  initial begin
    checks = 0;
    errors = 0;

    vt[0] = '{1'b1, 5'd7,  32'h1234_5678, 5'd31, 5'd0,
              32'h0, 32'h0, 32'h0, 32'h0};
    vt[1] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd7,  5'd0,
              32'h1234_5678, 32'h0, 32'h1234_5678, 32'h0};
    vt[2] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd31,
              32'h1234_5678, 32'hFFFF_FFFF,
              32'h1234_5678, 32'hFFFF_FFFF};
    vt[3] = '{1'b0, 5'd0,  32'h0,         5'd7,  5'd7,
              32'h1234_5678, 32'h1234_5678,
              32'h1234_5678, 32'h1234_5678};
    vt[4] = '{1'b1, 5'd0,  32'hA5A5_A5A5, 5'd0,  5'd7,
              32'h0, 32'h1234_5678, 32'h0, 32'h1234_5678};
    vt[5] = '{1'b0, 5'd12, 32'hCAFE_F00D, 5'd12, 5'd0,
              32'h0, 32'h0, 32'h0, 32'h0};
    vt[6] = '{1'b1, 5'd3,  32'h0000_0011, 5'd7,  5'd31,
              32'h1234_5678, 32'hFFFF_FFFF,
              32'h1234_5678, 32'hFFFF_FFFF};
    vt[7] = '{1'b1, 5'd20, 32'h0BAD_C0DE, 5'd3,  5'd12,
              32'h11, 32'h0, 32'h11, 32'h0};
    vt[8] = '{1'b0, 5'd0,  32'h0,         5'd20, 5'd3,
              32'h0BAD_C0DE, 32'h11, 32'h0BAD_C0DE, 32'h11};

    // Reset and init with a write held on the port throughout
    rst_n = 1'b0;
    WE3   = 1'b1;
    A3    = 5'd5;
    WD3   = 32'hDEAD_BEEF;
    A1    = 5'd5;
    A2    = 5'd0;
    #1;
    chk("reset_ready", {31'b0, rf_ready}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold_ready", {31'b0, rf_ready}, 32'h0);
    rst_n = 1'b1;
    wait_ready(n);
    chk("init_edges", n, 32'd31);
    WE3 = 1'b0;
    #1;
    chk("init_x5_ignored", RD1, 32'h0);

    foreach (vt[i]) begin
      WE3 = vt[i].we;
      A3  = vt[i].a3;
      WD3 = vt[i].wd;
      A1  = vt[i].a1;
      A2  = vt[i].a2;
      #1;
      chk($sformatf("v%0d_pre_rd1", i), RD1, vt[i].pre1);
      chk($sformatf("v%0d_pre_rd2", i), RD2, vt[i].pre2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_post_rd1", i), RD1, vt[i].post1);
      chk($sformatf("v%0d_post_rd2", i), RD2, vt[i].post2);
    end

    // Read-during-write on x3 (holds 0x11)
    WE3 = 1'b1;
    A3  = 5'd3;
    WD3 = 32'h22;
    A1  = 5'd3;
    A2  = 5'd3;
`ifdef RF_BYPASS_EN
    exp_rdw = 32'h22;
`else
    exp_rdw = 32'h11;
`endif
    #1;
    chk("rdw_pre_rd1", RD1, exp_rdw);
    chk("rdw_pre_rd2", RD2, exp_rdw);
    @(posedge clk);
    #1;
    WE3 = 1'b0;
    #1;
    chk("rdw_post_rd1", RD1, 32'h22);
    chk("rdw_post_rd2", RD2, 32'h22);

    // Reset pulse partway through the clear sequence
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midclr_ready_lo", {31'b0, rf_ready}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midclr_pulse_ready", {31'b0, rf_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n);
    chk("midclr_edges", n, 32'd31);

    // Reset from READY drops rf_ready without a clock edge
    WE3 = 1'b1;
    A3  = 5'd9;
    WD3 = 32'h55;
    @(posedge clk);
    #1;
    WE3 = 1'b0;
    A1  = 5'd9;
    #1;
    chk("ready_x9_written", RD1, 32'h55);
    rst_n = 1'b0;
    #1;
    chk("ready_rst_async", {31'b0, rf_ready}, 32'h0);
    chk("clear_read_zero", RD1, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n);
    chk("reinit_edges", n, 32'd31);
    A2 = 5'd7;
    #1;
    chk("reinit_x9", RD1, 32'h0);
    chk("reinit_x7", RD2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
